// File: rtl/mem_pkg.sv
// mem_pkg - shared types for the MIPS MEM stage: access size encoding,
// WB control bit positions and the wait-state FSM encoding.
package mem_pkg;

  // Access size as carried on mem_size_i; 2'b11 is decoded as a word.
  typedef enum logic [1:0] {
    MEM_B = 2'b00,
    MEM_H = 2'b01,
    MEM_W = 2'b10
  } mem_size_e;

  // Bit positions inside the 2-bit WB control bundle {MemtoReg, RegWrite}.
  localparam int WB_REG_WRITE  = 0;
  localparam int WB_MEM_TO_REG = 1;

  // Access sequencer: IDLE accepts a request, WAIT burns the wait states.
  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_e;

endpackage

// File: rtl/dmem_ram.sv
// dmem_ram - single-port data memory: synchronous byte-enabled write,
// asynchronous read. The array stores each word XORed with its power-up
// image, so a zero-initialised array reads back the INIT_MODE contents
// (0 = all zero, 1 = word[i] = i) without any initial block.
module dmem_ram #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 1024,
  parameter int INIT_MODE = 1,
  localparam int NB       = DATA_W / 8,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [NB-1:0]     be,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] delta [DEPTH] = '{default: '0};
  logic [DATA_W-1:0] image_word;

  // Power-up contents of the word at a given index.
  function automatic logic [DATA_W-1:0] init_word(input logic [AW-1:0] idx);
    if (INIT_MODE == 1) begin
      init_word = DATA_W'(idx);
    end else begin
      init_word = '0;
    end
  endfunction

  assign image_word = init_word(addr);
  assign rdata      = delta[addr] ^ image_word;

  // Commit the enabled byte lanes of a store.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) begin
          delta[addr][8*i +: 8] <= wdata[8*i +: 8] ^ image_word[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/mem_stage_dmem.sv
// mem_stage_dmem - MIPS MEM pipeline stage: big-endian byte/half/word
// loads and stores with sign/zero extension, WAIT_STATES extra cycles per
// access (mem_busy_o stalls upstream), registered MEM/WB outputs.
// Optional build macro MEM_ALIGN_CHECK_EN: misaligned half/word accesses are
// suppressed and flagged on misalign_o; without it the low address bits are
// forced to natural alignment and misalign_o stays 0.
module mem_stage_dmem
  import mem_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 0,
  parameter int INIT_MODE   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        wb_mem_i,
  input  logic              mem_read_i,
  input  logic              mem_write_i,
  input  logic [1:0]        mem_size_i,
  input  logic              mem_unsigned_i,
  input  logic [DATA_W-1:0] address_mem_i,
  input  logic [DATA_W-1:0] write_data_i,
  input  logic [4:0]        write_register_i,
  output logic [DATA_W-1:0] read_data_o,
  output logic [DATA_W-1:0] address_wb_o,
  output logic [1:0]        wb_o,
  output logic [4:0]        write_register_o,
  output logic              mem_busy_o,
  output logic              misalign_o
);

  localparam int NB = DATA_W / 8;
  localparam int OW = $clog2(NB);
  localparam int AW = $clog2(DEPTH);
  localparam logic [2:0] WS = 3'(WAIT_STATES);

  mem_state_e        state, state_next;
  logic [2:0]        cnt, cnt_next;
  logic              req, suppress, busy, complete, ram_we;
  logic              is_half, is_word;
  logic [OW:0]       nbytes, lane_pos;
  logic [OW-1:0]     off_raw, off;
  logic [NB-1:0]     size_mask, be;
  logic [DATA_W-1:0] wdata_lane, rdata_word, rdata_shift, load_val;

  assign req     = mem_read_i | mem_write_i;
  assign off_raw = address_mem_i[OW-1:0];

  // Decode the access size into byte count and lane mask.
  always_comb begin
    is_half   = 1'b0;
    is_word   = 1'b0;
    nbytes    = (OW+1)'(NB);
    size_mask = '1;
    case (mem_size_i)
      MEM_B: begin
        nbytes    = (OW+1)'(1);
        size_mask = NB'(1);
      end
      MEM_H: begin
        is_half   = 1'b1;
        nbytes    = (OW+1)'(2);
        size_mask = NB'(3);
      end
      default: begin
        is_word   = 1'b1;
        nbytes    = (OW+1)'(NB);
        size_mask = '1;
      end
    endcase
  end

`ifdef MEM_ALIGN_CHECK_EN
  assign suppress = req & ((is_half & off_raw[0]) | (is_word & (off_raw != '0)));
`else
  assign suppress = 1'b0;
`endif

  // Natural alignment of the offset, then big-endian lane position:
  // offset 0 maps to the most significant byte.
  always_comb begin
    off         = off_raw & ~(nbytes[OW-1:0] - OW'(1));
    lane_pos    = (OW+1)'(NB) - {1'b0, off} - nbytes;
    be          = size_mask << lane_pos;
    wdata_lane  = write_data_i << {lane_pos, 3'b000};
    rdata_shift = rdata_word >> {lane_pos, 3'b000};
  end

  // Sign- or zero-extend the selected lane.
  always_comb begin
    load_val = rdata_shift;
    case (mem_size_i)
      MEM_B: begin
        if (mem_unsigned_i) begin
          load_val = {{(DATA_W-8){1'b0}}, rdata_shift[7:0]};
        end else begin
          load_val = {{(DATA_W-8){rdata_shift[7]}}, rdata_shift[7:0]};
        end
      end
      MEM_H: begin
        if (mem_unsigned_i) begin
          load_val = {{(DATA_W-16){1'b0}}, rdata_shift[15:0]};
        end else begin
          load_val = {{(DATA_W-16){rdata_shift[15]}}, rdata_shift[15:0]};
        end
      end
      default: load_val = rdata_shift;
    endcase
  end

  // Wait-state sequencer: next state, stall request and completion strobe.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    busy       = 1'b0;
    complete   = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          if (suppress || (WS == 3'd0)) begin
            complete = 1'b1;
          end else begin
            busy       = 1'b1;
            state_next = WAIT;
            cnt_next   = WS - 3'd1;
          end
        end else begin
          complete = 1'b0;
        end
      end
      WAIT: begin
        if (cnt == 3'd0) begin
          complete   = 1'b1;
          state_next = IDLE;
        end else begin
          busy     = 1'b1;
          cnt_next = cnt - 3'd1;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 3'd0;
      end
    endcase
  end

  assign mem_busy_o = busy;
  assign ram_we     = complete & mem_write_i & ~suppress & rst_n;

  // Sequencer state and wait counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 3'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // MEM/WB register: bubble while stalled, result otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      read_data_o      <= '0;
      address_wb_o     <= '0;
      wb_o             <= 2'b00;
      write_register_o <= 5'd0;
      misalign_o       <= 1'b0;
    end else if (busy) begin
      wb_o       <= 2'b00;
      misalign_o <= 1'b0;
    end else begin
      read_data_o      <= (complete && mem_read_i && !mem_write_i && !suppress) ? load_val : '0;
      address_wb_o     <= address_mem_i;
      wb_o             <= suppress ? 2'b00 : wb_mem_i;
      write_register_o <= write_register_i;
      misalign_o       <= suppress;
    end
  end

  dmem_ram #(
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .INIT_MODE (INIT_MODE)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .be    (be),
    .addr  (address_mem_i[AW+OW-1:OW]),
    .wdata (wdata_lane),
    .rdata (rdata_word)
  );

endmodule

// File: tb/tb_mem_stage_dmem.sv
// tb_mem_stage_dmem - drives one instance without wait states and one with
// two wait states from shared inputs; a byte-array reference model per
// instance predicts load data, commits and stall behaviour.
module tb_mem_stage_dmem;

  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  wb_mem;
  logic        mem_read, mem_write, mem_unsigned;
  logic [1:0]  mem_size;
  logic [31:0] address_mem, write_data;
  logic [4:0]  write_register;

  logic [31:0] rd_o [2];
  logic [31:0] aw_o [2];
  logic [1:0]  wb_o [2];
  logic [4:0]  wr_o [2];
  logic        busy_o [2];
  logic        mis_o [2];

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] mdl [2][DEPTH*4];

  always #5 clk = ~clk;

  mem_stage_dmem #(.DATA_W(32), .DEPTH(DEPTH), .WAIT_STATES(0), .INIT_MODE(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .wb_mem_i(wb_mem), .mem_read_i(mem_read),
    .mem_write_i(mem_write), .mem_size_i(mem_size), .mem_unsigned_i(mem_unsigned),
    .address_mem_i(address_mem), .write_data_i(write_data), .write_register_i(write_register),
    .read_data_o(rd_o[0]), .address_wb_o(aw_o[0]), .wb_o(wb_o[0]),
    .write_register_o(wr_o[0]), .mem_busy_o(busy_o[0]), .misalign_o(mis_o[0]));

  mem_stage_dmem #(.DATA_W(32), .DEPTH(DEPTH), .WAIT_STATES(2), .INIT_MODE(1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .wb_mem_i(wb_mem), .mem_read_i(mem_read),
    .mem_write_i(mem_write), .mem_size_i(mem_size), .mem_unsigned_i(mem_unsigned),
    .address_mem_i(address_mem), .write_data_i(write_data), .write_register_i(write_register),
    .read_data_o(rd_o[1]), .address_wb_o(aw_o[1]), .wb_o(wb_o[1]),
    .write_register_o(wr_o[1]), .mem_busy_o(busy_o[1]), .misalign_o(mis_o[1]));

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input int d);
    chk_eq($sformatf("rst_rd%0d", d), rd_o[d], 32'h0);
    chk_eq($sformatf("rst_aw%0d", d), aw_o[d], 32'h0);
    chk_eq($sformatf("rst_ctl%0d", d), {24'h0, wb_o[d], wr_o[d], mis_o[d]}, 32'h0);
  endtask

  function automatic int size_bytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  // Big-endian load from the model: word wraps modulo DEPTH, offset aligned down.
  function automatic logic [31:0] mdl_load(input int d, input logic [31:0] a, input int nb,
                                           input logic uns);
    int base, off;
    logic [31:0] v;
    base = int'((a >> 2) % DEPTH) * 4;
    off  = int'(a % 4);
    off  = off - (off % nb);
    v    = 32'h0;
    for (int i = 0; i < nb; i++) v = (v << 8) | 32'(mdl[d][base+off+i]);
    if (!uns && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
    return v;
  endfunction

  task automatic mdl_store(input int d, input logic [31:0] a, input int nb, input logic [31:0] data);
    int base, off;
    base = int'((a >> 2) % DEPTH) * 4;
    off  = int'(a % 4);
    off  = off - (off % nb);
    for (int i = 0; i < nb; i++) mdl[d][base+off+i] = 8'(data >> (8*(nb-1-i)));
  endtask

  // One access held until the wait-state instance finishes; rst_cycle>0
  // pulls rst_n low during that cycle of the access.
  task automatic access(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] data, input logic [1:0] wb,
                        input logic [4:0] rg, input int rst_cycle,
                        output logic [31:0] r0, output logic [31:0] r2);
    int nb, n;
    logic req, supp, aborted;
    logic [31:0] exp_rd [2];
    nb  = size_bytes(sz);
    req = rd | wr;
    supp = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    supp = req && ((addr % 4) % nb != 0);
`endif
    n = (req && !supp) ? 3 : 1;
    for (int d = 0; d < 2; d++) exp_rd[d] = (rd && !wr && !supp) ? mdl_load(d, addr, nb, uns) : 32'h0;
    mem_read = rd; mem_write = wr; mem_size = sz; mem_unsigned = uns;
    address_mem = addr; write_data = data; wb_mem = wb; write_register = rg;
    aborted = 1'b0;
    for (int k = 1; k <= n; k++) begin
      rst_n = (k == rst_cycle) ? 1'b0 : 1'b1;
      #1;
      if (rst_n) begin
        chk_eq("busy0", 32'(busy_o[0]), 32'h0);
        chk_eq("busy2", 32'(busy_o[1]), 32'(k < n));
      end
      @(posedge clk);
      #1;
      if (k == rst_cycle) begin
        aborted = 1'b1;
        chk_zero(0);
        chk_zero(1);
        break;
      end
      if (k < n) chk_eq("bubble_wb2", 32'(wb_o[1]), 32'h0);
    end
    if (!aborted) begin
      for (int d = 0; d < 2; d++) begin
        chk_eq($sformatf("rd%0d", d), rd_o[d], exp_rd[d]);
        chk_eq($sformatf("aw%0d", d), aw_o[d], addr);
        chk_eq($sformatf("wb%0d", d), 32'(wb_o[d]), supp ? 32'h0 : 32'(wb));
        chk_eq($sformatf("wr%0d", d), 32'(wr_o[d]), 32'(rg));
        chk_eq($sformatf("mis%0d", d), 32'(mis_o[d]), 32'(supp));
      end
    end
    if (wr && !supp) begin
      if (!(aborted && rst_cycle == 1)) mdl_store(0, addr, nb, data);
      if (!aborted) mdl_store(1, addr, nb, data);
    end
    r0 = rd_o[0];
    r2 = rd_o[1];
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] r0, r2, exp6;
    int op;
    logic [31:0] a;
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < DEPTH; i++)
        for (int b = 0; b < 4; b++) mdl[d][4*i+b] = 8'(i >> (8*(3-b)));

    rst_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0; mem_size = 2'b10; mem_unsigned = 1'b0;
    address_mem = 32'h1234_5678; write_data = 32'hCAFE_F00D; wb_mem = 2'b11; write_register = 5'd9;
    repeat (2) @(posedge clk);
    #1;
    chk_zero(0);
    chk_zero(1);
    chk_eq("rst_busy2", 32'(busy_o[1]), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    access(1'b1, 1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 2'b11, 5'd3, 0, r0, r2);
    chk_eq("t1_lw0", r0, 32'h0000_0002);
    chk_eq("t1_lw2", r2, 32'h0000_0002);
    access(1'b0, 1'b1, 2'b00, 1'b0, 32'h5, 32'h0000_00AB, 2'b00, 5'd0, 0, r0, r2);
    access(1'b1, 1'b0, 2'b00, 1'b1, 32'h5, 32'h0, 2'b11, 5'd4, 0, r0, r2);
    chk_eq("t2_lbu", r0, 32'h0000_00AB);
    access(1'b1, 1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 2'b11, 5'd4, 0, r0, r2);
    chk_eq("t2_lw", r0, 32'h00AB_0001);
    access(1'b0, 1'b1, 2'b01, 1'b0, 32'h10, 32'h0000_8001, 2'b00, 5'd0, 0, r0, r2);
    access(1'b1, 1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 2'b11, 5'd5, 0, r0, r2);
    chk_eq("t3_lh", r0, 32'hFFFF_8001);
    access(1'b1, 1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 2'b11, 5'd5, 0, r0, r2);
    chk_eq("t3_lhu", r2, 32'h0000_8001);
    access(1'b1, 1'b0, 2'b10, 1'b0, 32'hC, 32'h0, 2'b11, 5'd6, 0, r0, r2);
    chk_eq("t4_lw2", r2, 32'h0000_0003);
    access(1'b0, 1'b1, 2'b10, 1'b0, 32'h20, 32'hDEAD_BEEF, 2'b00, 5'd0, 2, r0, r2);
    access(1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 2'b11, 5'd7, 0, r0, r2);
    chk_eq("t5_lw2", r2, 32'h0000_0008);
    chk_eq("t5_lw0", r0, 32'hDEAD_BEEF);
    access(1'b0, 1'b1, 2'b10, 1'b0, 32'h6, 32'h1234_5678, 2'b00, 5'd0, 0, r0, r2);
    access(1'b1, 1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 2'b11, 5'd8, 0, r0, r2);
`ifdef MEM_ALIGN_CHECK_EN
    exp6 = 32'h00AB_0001;
`else
    exp6 = 32'h1234_5678;
`endif
    chk_eq("t6_lw", r2, exp6);
    access(1'b1, 1'b1, 2'b10, 1'b0, 32'h30, 32'h5555_AAAA, 2'b11, 5'd9, 0, r0, r2);
    access(1'b0, 1'b0, 2'b10, 1'b0, 32'h9999_0000, 32'h0, 2'b10, 5'd10, 0, r0, r2);

    // Randomised traffic
    for (int i = 0; i < 300; i++) begin
      op = int'($urandom_range(0, 9));
      a  = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 95)) : $urandom;
      access((op <= 3) || (op == 7), (op >= 4) && (op <= 7), 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), a, $urandom, 2'($urandom_range(0, 3)),
             5'($urandom_range(0, 31)), ($urandom_range(0, 19) == 0) ? 2 : 0, r0, r2);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
